mem_port_arbiter: RTL and testbench

Shares the core's single memory port between the instruction-fetch unit and the load/store unit. Requests are accepted with a req/gnt handshake, one transaction is outstanding on the memory port at a time, and each response is routed back to its owner. Data accesses have priority, with a starvation limit that guarantees fetch progress. A fetch flush from the PC redirect logic (jal/jalr/branch) discards the response of an in-flight fetch.

---
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and load/store
// Data wins arbitration unless fetch has waited STARVE_LIMIT data grants; one transaction in flight.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        i_flush,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic        busy
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;          // 1 = fetch, 0 = data
  logic [CW-1:0]   starve_cnt_q, starve_cnt_d;
  logic            flush_pend_q, flush_pend_d;
  logic            m_req_q, m_req_d;
  logic            m_we_q, m_we_d;
  logic [3:0]      m_be_q, m_be_d;
  logic [31:0]     m_addr_q, m_addr_d;
  logic [31:0]     m_wdata_q, m_wdata_d;
  logic            fetch_win;

  assign fetch_win = i_req && (!d_req || (starve_cnt_q == LIMIT));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      starve_cnt_q <= '0;
      flush_pend_q <= 1'b0;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_be_q       <= 4'h0;
      m_addr_q     <= 32'h0;
      m_wdata_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      flush_pend_q <= flush_pend_d;
      m_req_q      <= m_req_d;
      m_we_q       <= m_we_d;
      m_be_q       <= m_be_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    flush_pend_d = flush_pend_q;
    m_req_d      = m_req_q;
    m_we_d       = m_we_q;
    m_be_d       = m_be_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    i_gnt        = 1'b0;
    d_gnt        = 1'b0;
    i_rvalid     = 1'b0;
    d_rvalid     = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          owner_d = fetch_win;
          m_req_d = 1'b1;
          state_d = ISSUE;
          if (fetch_win) begin
            m_we_d    = 1'b0;
            m_be_d    = 4'hF;
            m_addr_d  = i_addr;
            m_wdata_d = 32'h0;
          end else begin
            m_we_d    = d_we;
            m_be_d    = d_be;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
          end
        end
      end
      ISSUE: begin
        if (owner_q && i_flush) flush_pend_d = 1'b1;
        if (m_gnt) begin
          i_gnt   = owner_q;
          d_gnt   = !owner_q;
          m_req_d = 1'b0;
          state_d = WAIT;
          // Fetch grants reset the starvation window; data grants count only while fetch waits.
          if (owner_q) starve_cnt_d = '0;
          else if (i_req && (starve_cnt_q != LIMIT)) starve_cnt_d = starve_cnt_q + CW'(1);
        end
      end
      WAIT: begin
        if (owner_q && i_flush) flush_pend_d = 1'b1;
        if (m_rvalid) begin
          d_rvalid     = !owner_q;
          i_rvalid     = owner_q && !i_flush && !flush_pend_q;
          flush_pend_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_be    = m_be_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_req, i_flush, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_req, m_we, m_gnt, m_rvalid, busy;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int n_chk = 0;
  int n_bad = 0;
  int n_ig = 0, n_dg = 0, n_irv = 0, n_drv = 0;
  int s_ig, s_dg, s_irv, s_drv;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rstn(rstn),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy)
  );

  always @(posedge clk) begin
    if (i_gnt)    n_ig  <= n_ig + 1;
    if (d_gnt)    n_dg  <= n_dg + 1;
    if (i_rvalid) n_irv <= n_irv + 1;
    if (d_rvalid) n_drv <= n_drv + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_ig = n_ig; s_dg = n_dg; s_irv = n_irv; s_drv = n_drv;
  endtask

  task automatic chk_counts(input string tag, input int ig, input int dg, input int irv, input int drv);
    chk({tag, "_ignt_cnt"}, 32'(n_ig - s_ig), 32'(ig));
    chk({tag, "_dgnt_cnt"}, 32'(n_dg - s_dg), 32'(dg));
    chk({tag, "_irv_cnt"},  32'(n_irv - s_irv), 32'(irv));
    chk({tag, "_drv_cnt"},  32'(n_drv - s_drv), 32'(drv));
  endtask

  // flush_mode: 0 none, 1 pulse i_flush in first WAIT cycle, 2 i_flush together with m_rvalid
  task automatic txn(input string tag, input logic exp_fetch, input logic [31:0] exp_addr,
                     input logic exp_we, input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                     input logic [31:0] rdata, input int rsp_wait, input int flush_mode,
                     input logic exp_rv, input logic keep_d);
    int n;
    n = 0;
    while (m_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_m_req"}, 32'(m_req), 32'h1);
    chk({tag, "_m_addr"}, m_addr, exp_addr);
    chk({tag, "_m_we"}, 32'(m_we), 32'(exp_we));
    chk({tag, "_m_be"}, 32'(m_be), 32'(exp_be));
    chk({tag, "_m_wdata"}, m_wdata, exp_wdata);
    m_gnt = 1'b1;
    #1;
    chk({tag, "_i_gnt"}, 32'(i_gnt), 32'(exp_fetch));
    chk({tag, "_d_gnt"}, 32'(d_gnt), 32'(!exp_fetch));
    @(negedge clk);
    m_gnt = 1'b0;
    if (exp_fetch) i_req = 1'b0;
    else if (!keep_d) d_req = 1'b0;
    #1;
    chk({tag, "_m_req_drop"}, 32'(m_req), 32'h0);
    chk({tag, "_busy_wait"}, 32'(busy), 32'h1);
    for (int k = 0; k < rsp_wait; k++) begin
      if (flush_mode == 1 && k == 0) i_flush = 1'b1;
      #1;
      chk({tag, "_early_rv"}, 32'(i_rvalid | d_rvalid), 32'h0);
      @(negedge clk);
      i_flush = 1'b0;
    end
    m_rvalid = 1'b1;
    m_rdata  = rdata;
    if (flush_mode == 2) i_flush = 1'b1;
    #1;
    chk({tag, "_i_rvalid"}, 32'(i_rvalid), 32'(exp_fetch && exp_rv));
    chk({tag, "_d_rvalid"}, 32'(d_rvalid), 32'(!exp_fetch));
    chk({tag, "_rdata"}, exp_fetch ? i_rdata : d_rdata, rdata);
    @(negedge clk);
    m_rvalid = 1'b0;
    m_rdata  = 32'h0;
    i_flush  = 1'b0;
  endtask

  initial begin
    logic [5:0] order;
    rstn = 1'b0; i_req = 1'b0; i_addr = 32'h0; i_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_m_req", 32'(m_req), 32'h0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_m_be", 32'(m_be), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_starve", 32'(dut.starve_cnt_q), 32'h0);
    rstn = 1'b1;
    @(negedge clk);

    // single fetch, data returned 2 cycles after grant
    snap();
    i_req = 1'b1; i_addr = 32'h100;
    txn("fetch", 1'b1, 32'h100, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, 1, 0, 1'b1, 1'b0);
    chk_counts("fetch", 1, 0, 1, 0);

    // store
    snap();
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h2004; d_wdata = 32'h1234;
    txn("store", 1'b0, 32'h2004, 1'b1, 4'b0011, 32'h1234, 32'h0, 1, 0, 1'b0, 1'b0);
    #1;
    chk("store_busy_after", 32'(busy), 32'h0);
    chk_counts("store", 0, 1, 0, 1);

    // starvation: data held for 6 transactions, fetch pending
    d_we = 1'b0; d_be = 4'hF; d_addr = 32'h3000; d_wdata = 32'h0;
    d_req = 1'b1; i_req = 1'b1; i_addr = 32'h200;
    order = 6'b010000;
    for (int k = 0; k < 6; k++) begin
      if (order[k])
        txn("starve_i", 1'b1, 32'h200, 1'b0, 4'hF, 32'h0, 32'h5000 + 32'(k), 1, 0, 1'b1, 1'b1);
      else
        txn("starve_d", 1'b0, 32'h3000, 1'b0, 4'hF, 32'h0, 32'h5000 + 32'(k), 1, 0, 1'b0, k != 5);
      if (k == 3) chk("starve_cnt_sat", 32'(dut.starve_cnt_q), 32'h4);
      if (k == 4) chk("starve_cnt_clr", 32'(dut.starve_cnt_q), 32'h0);
    end
    #1;
    chk("starve_idle", 32'(busy), 32'h0);

    // flush in WAIT, then a normal fetch
    snap();
    i_req = 1'b1; i_addr = 32'h40;
    txn("flush_wait", 1'b1, 32'h40, 1'b0, 4'hF, 32'h0, 32'hAAAA0040, 2, 1, 1'b0, 1'b0);
    i_req = 1'b1; i_addr = 32'h80;
    txn("after_flush", 1'b1, 32'h80, 1'b0, 4'hF, 32'h0, 32'hBBBB0080, 1, 0, 1'b1, 1'b0);
    chk_counts("flush_wait", 2, 0, 1, 0);

    // flush coinciding with m_rvalid; flush during data owner; flush in IDLE
    snap();
    i_req = 1'b1; i_addr = 32'hC0;
    txn("flush_rv", 1'b1, 32'hC0, 1'b0, 4'hF, 32'h0, 32'hCCCC00C0, 1, 2, 1'b0, 1'b0);
    d_req = 1'b1; d_addr = 32'h4000;
    txn("flush_data", 1'b0, 32'h4000, 1'b0, 4'hF, 32'h0, 32'hDDDD4000, 2, 1, 1'b0, 1'b0);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    i_req = 1'b1; i_addr = 32'hE0;
    txn("flush_idle", 1'b1, 32'hE0, 1'b0, 4'hF, 32'h0, 32'hEEEE00E0, 1, 0, 1'b1, 1'b0);
    chk_counts("flush_mix", 2, 1, 1, 1);

    // reset while in WAIT, late response dropped
    snap();
    i_req = 1'b1; i_addr = 32'h300;
    @(negedge clk);
    m_gnt = 1'b1;
    @(negedge clk);
    m_gnt = 1'b0; i_req = 1'b0;
    rstn = 1'b0;
    #1;
    chk("rstw_busy", 32'(busy), 32'h0);
    chk("rstw_m_req", 32'(m_req), 32'h0);
    chk("rstw_m_addr", m_addr, 32'h0);
    chk("rstw_m_be", 32'(m_be), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    m_rvalid = 1'b1; m_rdata = 32'h99999999;
    #1;
    chk("rstw_i_rvalid", 32'(i_rvalid), 32'h0);
    chk("rstw_d_rvalid", 32'(d_rvalid), 32'h0);
    chk("rstw_busy_rv", 32'(busy), 32'h0);
    @(negedge clk);
    m_rvalid = 1'b0; m_rdata = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h5008;
    txn("post_rst", 1'b0, 32'h5008, 1'b0, 4'hF, 32'h0, 32'h12345678, 1, 0, 1'b0, 1'b0);
    chk_counts("rst_wait", 1, 1, 0, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
